// File: rtl/bluetile_endpoint.sv
// -----------------------------------------------------------------------------
// bluetile_endpoint
//
// Network-side endpoint for a bluetile peripheral.
//
// Request path (device -> host):
//   Request flits from the device are accepted whenever the RX FIFO has room.
//   They are deframed into header/payload flits and tagged with sop/eop. The
//   header carries an 8-bit payload length N at bit LEN_LSB, so a packet is
//   one header flit followed by N payload flits (0..255). The tagged flits go
//   into a first-word-fall-through FIFO that the host drains.
//
// Response path (host -> device):
//   Host words pass through a one-entry output register into the device. A
//   flit can be loaded in the same cycle as the previous one commits, so
//   streaming runs at one flit per cycle.
//
// Optional feature (macro BLUETILE_ENDPOINT_LENCHK_EN):
//   The TX framing FSM tracks the header length of outgoing packets. In BODY,
//   256 consecutive cycles without host_tx_valid set the sticky frame_err and
//   send the FSM back to HDR, so the next loaded flit is taken as a header.
//   Without the macro there is no stall counter and frame_err is tied to 0.
//
// Parameters:
//   FIFO_DEPTH  RX FIFO entries (power of two, >= 2)
//   LEN_LSB     bit position of the 8-bit length field in a header flit
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   dev_request_DOUT/valid   request flit offered by the device
//   dev_request_accept       request flit consumed this cycle
//   dev_response_DIN         response flit to the device (registered)
//   dev_response_canaccept   device can take a response flit
//   dev_response_commit      response flit transferred this cycle
//   host_rx_data/sop/eop     head-of-FIFO flit and its framing tags
//   host_rx_valid/ready      FIFO not empty / host pops the head
//   host_tx_data/valid       host response flit offered
//   host_tx_ready            endpoint takes the host flit this cycle
//   frame_err                sticky TX framing violation
// -----------------------------------------------------------------------------
module bluetile_endpoint #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_LSB    = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] dev_request_DOUT,
  input  logic        dev_request_valid,
  output logic        dev_request_accept,
  output logic [31:0] dev_response_DIN,
  input  logic        dev_response_canaccept,
  output logic        dev_response_commit,
  output logic [31:0] host_rx_data,
  output logic        host_rx_sop,
  output logic        host_rx_eop,
  output logic        host_rx_valid,
  input  logic        host_rx_ready,
  input  logic [31:0] host_tx_data,
  input  logic        host_tx_valid,
  output logic        host_tx_ready,
  output logic        frame_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_HDR,
    ST_BODY
  } frame_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } rx_entry_t;

  // ---------------------------------------------------------------------------
  // RX FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  rx_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rx_push;
  logic             rx_pop;
  rx_entry_t        push_entry;

  // RX deframer state
  frame_state_e     rx_state;
  logic [7:0]       rx_cnt;
  logic [7:0]       rx_len;

  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);

  // No pop bypass: a full FIFO refuses the flit even if the host pops this
  // cycle. Reset also masks accept so the device never sees a handshake
  // while the endpoint is being cleared.
  assign dev_request_accept = dev_request_valid & ~fifo_full & ~RST;

  assign rx_push = dev_request_accept;
  assign rx_pop  = host_rx_valid & host_rx_ready;
  assign rx_len  = dev_request_DOUT[LEN_LSB +: 8];

  // Tag the incoming flit from the deframer state it arrives in.
  always_comb begin
    push_entry      = '0;
    push_entry.data = dev_request_DOUT;
    if (rx_state == ST_HDR) begin
      push_entry.sop = 1'b1;
      push_entry.eop = (rx_len == 8'd0);
    end else begin
      push_entry.sop = 1'b0;
      push_entry.eop = (rx_cnt == 8'd1);
    end
  end

  // NOTE: the storage array has no reset; an entry is only observed after a
  // push has written it, so clearing the pointers and count is enough.
  always_ff @(posedge CLK) begin
    if (rx_push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of block order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (rx_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rx_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // First-word-fall-through head.
  assign host_rx_valid = ~fifo_empty;
  assign host_rx_data  = fifo_mem[rd_ptr].data;
  assign host_rx_sop   = fifo_mem[rd_ptr].sop;
  assign host_rx_eop   = fifo_mem[rd_ptr].eop;

  // ---------------------------------------------------------------------------
  // RX deframer: advances only on accepted flits
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state <= ST_HDR;
      rx_cnt   <= 8'd0;
    end else if (rx_push) begin
      case (rx_state)
        ST_HDR: begin
          rx_cnt <= rx_len;
          if (rx_len != 8'd0) rx_state <= ST_BODY;
        end
        ST_BODY: begin
          rx_cnt <= rx_cnt - 8'd1;
          if (rx_cnt == 8'd1) rx_state <= ST_HDR;
        end
        default: rx_state <= ST_HDR;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX output register
  // ---------------------------------------------------------------------------
  logic        tx_full;
  logic [31:0] din_q;
  logic        tx_load;

  // The register can take a new word when it is empty or its current word
  // leaves this very cycle.
  assign host_tx_ready       = ~tx_full | dev_response_canaccept;
  assign tx_load             = host_tx_valid & host_tx_ready;
  assign dev_response_commit = tx_full & dev_response_canaccept;
  assign dev_response_DIN    = din_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_full <= 1'b0;
      din_q   <= 32'd0;
    end else if (tx_load) begin
      // A load alongside a commit replaces the departing word.
      tx_full <= 1'b1;
      din_q   <= host_tx_data;
    end else if (dev_response_commit) begin
      tx_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX framing FSM: advances on loads with the same HDR/BODY rules as RX
  // ---------------------------------------------------------------------------
  frame_state_e tx_state;
  logic [7:0]   tx_cnt;
  logic [7:0]   tx_len;

  assign tx_len = host_tx_data[LEN_LSB +: 8];

`ifdef BLUETILE_ENDPOINT_LENCHK_EN
  logic [7:0] stall_cnt;
  logic       frame_err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state    <= ST_HDR;
      tx_cnt      <= 8'd0;
      stall_cnt   <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      if (tx_load) begin
        case (tx_state)
          ST_HDR: begin
            tx_cnt <= tx_len;
            if (tx_len != 8'd0) tx_state <= ST_BODY;
          end
          ST_BODY: begin
            tx_cnt <= tx_cnt - 8'd1;
            if (tx_cnt == 8'd1) tx_state <= ST_HDR;
          end
          default: tx_state <= ST_HDR;
        endcase
      end

      // Idle watchdog inside a packet body. The 256th consecutive idle cycle
      // (counter already at 255) abandons the packet.
      if (tx_state == ST_BODY && !host_tx_valid) begin
        if (stall_cnt == 8'd255) begin
          frame_err_q <= 1'b1;
          tx_state    <= ST_HDR;
          stall_cnt   <= 8'd0;
        end else begin
          stall_cnt <= stall_cnt + 8'd1;
        end
      end else begin
        stall_cnt <= 8'd0;
      end
    end
  end

  assign frame_err = frame_err_q;
`else
  // Without the length check the FSM only tracks packet position; nothing
  // downstream depends on it and frame_err is constant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state <= ST_HDR;
      tx_cnt   <= 8'd0;
    end else if (tx_load) begin
      case (tx_state)
        ST_HDR: begin
          tx_cnt <= tx_len;
          if (tx_len != 8'd0) tx_state <= ST_BODY;
        end
        ST_BODY: begin
          tx_cnt <= tx_cnt - 8'd1;
          if (tx_cnt == 8'd1) tx_state <= ST_HDR;
        end
        default: tx_state <= ST_HDR;
      endcase
    end
  end

  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_bluetile_endpoint.sv
// -----------------------------------------------------------------------------
// tb_bluetile_endpoint
//
// Self-checking bench for bluetile_endpoint. A packet-level model (queues of
// tagged flits plus a one-slot TX queue) predicts every output each cycle;
// directed sections pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_bluetile_endpoint;

  localparam int DEPTH   = 8;
  localparam int LEN_LSB = 0;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } flit_t;

  logic        CLK;
  logic        RST;
  logic [31:0] dev_request_DOUT;
  logic        dev_request_valid;
  logic        dev_request_accept;
  logic [31:0] dev_response_DIN;
  logic        dev_response_canaccept;
  logic        dev_response_commit;
  logic [31:0] host_rx_data;
  logic        host_rx_sop;
  logic        host_rx_eop;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic [31:0] host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic        frame_err;

  bluetile_endpoint #(.FIFO_DEPTH(DEPTH), .LEN_LSB(LEN_LSB)) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .dev_request_DOUT      (dev_request_DOUT),
    .dev_request_valid     (dev_request_valid),
    .dev_request_accept    (dev_request_accept),
    .dev_response_DIN      (dev_response_DIN),
    .dev_response_canaccept(dev_response_canaccept),
    .dev_response_commit   (dev_response_commit),
    .host_rx_data          (host_rx_data),
    .host_rx_sop           (host_rx_sop),
    .host_rx_eop           (host_rx_eop),
    .host_rx_valid         (host_rx_valid),
    .host_rx_ready         (host_rx_ready),
    .host_tx_data          (host_tx_data),
    .host_tx_valid         (host_tx_valid),
    .host_tx_ready         (host_tx_ready),
    .frame_err             (frame_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs (percent chance per cycle)
  int p_rx_valid = 0;
  int p_rx_ready = 0;
  int p_tx_valid = 0;
  int p_can      = 0;

  // Sources and model state
  flit_t rx_src[$];     // flits the device still has to send
  flit_t rx_q[$];       // expected FIFO contents
  flit_t tx_src[$];     // flits the host still has to send
  flit_t tx_q[$];       // expected content of the output register (0 or 1)
  flit_t pop_log[$];    // flits the host popped
  logic [31:0] commit_log[$];
  int          commit_cyc[$];
  logic [31:0] din_m    = 32'd0;
  logic        err_m    = 1'b0;
  logic        in_body  = 1'b0;
  int          idle_cnt = 0;
  int          rx_gen_rem = 0;
  int          tx_gen_rem = 0;
  int          acc_cnt  = 0;
  int          cyc      = 0;

  // Tag a flit by its position in the packet stream being generated.
  task automatic tag_flit(input logic [31:0] d, inout int rem, output flit_t f);
    f.data = d;
    if (rem == 0) begin
      rem   = int'(d[LEN_LSB +: 8]);
      f.sop = 1'b1;
      f.eop = (rem == 0);
    end else begin
      rem   = rem - 1;
      f.sop = 1'b0;
      f.eop = (rem == 0);
    end
  endtask

  task automatic push_rx(input logic [31:0] d);
    flit_t f;
    tag_flit(d, rx_gen_rem, f);
    rx_src.push_back(f);
  endtask

  task automatic push_tx(input logic [31:0] d);
    flit_t f;
    tag_flit(d, tx_gen_rem, f);
    tx_src.push_back(f);
  endtask

  task automatic rand_packet(input bit to_rx);
    logic [31:0] hdr;
    int n;
    n   = ($urandom_range(9) == 0) ? int'($urandom_range(20)) : int'($urandom_range(5));
    hdr = $urandom;
    hdr[LEN_LSB +: 8] = 8'(n);
    if (to_rx) push_rx(hdr); else push_tx(hdr);
    for (int i = 0; i < n; i++) begin
      if (to_rx) push_rx($urandom); else push_tx($urandom);
    end
  endtask

  function automatic bit chance(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Per-cycle driver, checker and model update.
  always begin
    bit exp_acc, exp_commit, exp_ready;
    @(negedge CLK);
    dev_request_valid      = (rx_src.size() != 0) && chance(p_rx_valid);
    dev_request_DOUT       = dev_request_valid ? rx_src[0].data : $urandom;
    host_rx_ready          = chance(p_rx_ready);
    host_tx_valid          = (tx_src.size() != 0) && chance(p_tx_valid);
    host_tx_data           = host_tx_valid ? tx_src[0].data : $urandom;
    dev_response_canaccept = chance(p_can);
    #1;
    if (RST) begin
      check("rst_accept", dev_request_accept, 0);
      check("rst_commit", dev_response_commit, 0);
      check("rst_rx_valid", host_rx_valid, 0);
      check("rst_din", dev_response_DIN, 0);
      check("rst_frame_err", frame_err, 0);
      rx_src.delete(); rx_q.delete(); tx_src.delete(); tx_q.delete();
      din_m = 0; err_m = 0; in_body = 0; idle_cnt = 0;
      rx_gen_rem = 0; tx_gen_rem = 0;
    end else begin
      exp_acc    = dev_request_valid && (rx_q.size() < DEPTH);
      exp_commit = (tx_q.size() != 0) && dev_response_canaccept;
      exp_ready  = (tx_q.size() == 0) || dev_response_canaccept;
      check("accept", dev_request_accept, exp_acc);
      check("rx_valid", host_rx_valid, rx_q.size() != 0);
      if (rx_q.size() != 0) begin
        check("rx_data", host_rx_data, rx_q[0].data);
        check("rx_sop", host_rx_sop, rx_q[0].sop);
        check("rx_eop", host_rx_eop, rx_q[0].eop);
      end
      check("commit", dev_response_commit, exp_commit);
      check("tx_ready", host_tx_ready, exp_ready);
      check("din", dev_response_DIN, din_m);
      check("frame_err", frame_err, err_m);

      if ((rx_q.size() != 0) && host_rx_ready) pop_log.push_back(rx_q.pop_front());
      if (exp_acc) begin
        rx_q.push_back(rx_src.pop_front());
        acc_cnt++;
      end
      if (exp_commit) begin
        commit_log.push_back(tx_q.pop_front().data);
        commit_cyc.push_back(cyc);
      end
`ifdef BLUETILE_ENDPOINT_LENCHK_EN
      if (host_tx_valid || !in_body) idle_cnt = 0;
      else begin
        idle_cnt++;
        if (idle_cnt == 256) begin
          err_m = 1; in_body = 0; idle_cnt = 0; tx_gen_rem = 0;
        end
      end
`endif
      if (host_tx_valid && exp_ready) begin
        din_m   = tx_src[0].data;
        in_body = !tx_src[0].eop;
        tx_q.push_back(tx_src.pop_front());
      end
      cyc++;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      #2;
    end
  endtask

  task automatic drain(input string name);
    int k;
    p_rx_valid = 100; p_rx_ready = 100; p_tx_valid = 100; p_can = 100;
    k = 0;
    while ((rx_src.size() + rx_q.size() + tx_src.size() + tx_q.size()) != 0 && k < 2000) begin
      step();
      k++;
    end
    check(name, k < 2000, 1);
    p_rx_valid = 0; p_rx_ready = 0; p_tx_valid = 0; p_can = 0;
    step(2);
  endtask

  initial begin
    int a0;
    RST = 1'b1;
    dev_request_valid = 0; dev_request_DOUT = 0; host_rx_ready = 0;
    host_tx_valid = 0; host_tx_data = 0; dev_response_canaccept = 0;
    step(3);
    check("reset_rx_valid", host_rx_valid, 0);
    check("reset_din", dev_response_DIN, 0);
    @(negedge CLK);
    RST = 1'b0;
    step(2);

    // Randomized traffic on both paths
    p_rx_valid = 60; p_rx_ready = 55; p_tx_valid = 70; p_can = 60;
    for (int i = 0; i < 3000; i++) begin
      if (rx_src.size() < 8) rand_packet(1);
      if (tx_src.size() < 8) rand_packet(0);
      step();
    end
    drain("drain_random");

    // Header-only packet
    pop_log.delete();
    p_rx_valid = 100;
    push_rx(32'h0A000000);
    step();
    check("hdr_only_accept", dev_request_accept, 1);
    step();
    check("hdr_only_valid", host_rx_valid, 1);
    check("hdr_only_data", host_rx_data, 32'h0A000000);
    check("hdr_only_sop", host_rx_sop, 1);
    check("hdr_only_eop", host_rx_eop, 1);
    drain("drain_hdr_only");

    // Three-payload packet, host always ready
    pop_log.delete();
    p_rx_valid = 100; p_rx_ready = 100;
    a0 = acc_cnt;
    push_rx(32'h00000003); push_rx(32'h11); push_rx(32'h22); push_rx(32'h33);
    step(7);
    check("p3_accepts", acc_cnt - a0, 4);
    check("p3_pops", pop_log.size(), 4);
    if (pop_log.size() == 4) begin
      check("p3_sop", {pop_log[0].sop, pop_log[1].sop, pop_log[2].sop, pop_log[3].sop}, 4'b1000);
      check("p3_eop", {pop_log[0].eop, pop_log[1].eop, pop_log[2].eop, pop_log[3].eop}, 4'b0001);
      check("p3_last", pop_log[3].data, 32'h33);
    end
    drain("drain_p3");

    // Full FIFO: 12 flits streamed with the host stalled
    pop_log.delete();
    p_rx_valid = 100; p_rx_ready = 0;
    a0 = acc_cnt;
    push_rx(32'h0000000B);
    for (int i = 1; i <= 11; i++) push_rx(32'(i));
    step(14);
    check("full_accepts", acc_cnt - a0, 8);
    check("full_accept_low", dev_request_accept, 0);
    p_rx_ready = 100;
    step();
    p_rx_ready = 0;
    check("full_pop_no_bypass", dev_request_accept, 0);
    step();
    check("full_accept_after_pop", dev_request_accept, 1);
    step(2);
    check("full_accepts_9", acc_cnt - a0, 9);
    drain("drain_full");
    check("full_pop_count", pop_log.size(), 12);
    for (int i = 0; i < pop_log.size(); i++)
      check("full_order", pop_log[i].data, (i == 0) ? 32'h0000000B : 32'(i));

    // TX backpressure
    commit_log.delete(); commit_cyc.delete();
    p_can = 0; p_tx_valid = 100;
    push_tx(32'hA1); push_tx(32'hA2);
    step(6);
    check("tx_bp_ready", host_tx_ready, 0);
    check("tx_bp_din", dev_response_DIN, 32'hA1);
    check("tx_bp_no_commit", commit_log.size(), 0);
    p_can = 100;
    step(4);
    check("tx_bp_commits", commit_log.size(), 2);
    if (commit_log.size() == 2) begin
      check("tx_bp_first", commit_log[0], 32'hA1);
      check("tx_bp_second", commit_log[1], 32'hA2);
      check("tx_bp_b2b", commit_cyc[1] - commit_cyc[0], 1);
    end
    p_can = 0; p_tx_valid = 0;

    // Reset mid-packet
    p_rx_valid = 100; p_rx_ready = 0;
    push_rx(32'h00000004); push_rx(32'h1); push_rx(32'h2);
    step(5);
    check("midpkt_before_rst", host_rx_valid, 1);
    RST = 1'b1;
    #1;
    check("midpkt_rst_accept", dev_request_accept, 0);
    check("midpkt_rst_rx_valid", host_rx_valid, 0);
    check("midpkt_rst_commit", dev_response_commit, 0);
    check("midpkt_rst_din", dev_response_DIN, 0);
    step(2);
    @(negedge CLK);
    RST = 1'b0;
    step();
    pop_log.delete();
    push_rx(32'h12345601); push_rx(32'h77);
    p_rx_ready = 100;
    step(6);
    check("midpkt_new_pops", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      check("midpkt_new_sop", pop_log[0].sop, 1);
      check("midpkt_new_hdr", pop_log[0].data, 32'h12345601);
      check("midpkt_new_eop", pop_log[1].eop, 1);
    end
    drain("drain_midpkt");

`ifdef BLUETILE_ENDPOINT_LENCHK_EN
    // Host abandons a packet mid-body
    commit_log.delete();
    p_can = 100; p_tx_valid = 100;
    push_tx(32'h00000002); push_tx(32'h55);
    step(200);
    check("lenchk_not_yet", frame_err, 0);
    step(100);
    check("lenchk_err", frame_err, 1);
    push_tx(32'h00000000);
    step(4);
    check("lenchk_next_commit", commit_log[commit_log.size()-1], 32'h0);
    check("lenchk_sticky", frame_err, 1);
`else
    p_can = 100; p_tx_valid = 100;
    push_tx(32'h00000002); push_tx(32'h55);
    step(300);
    check("no_lenchk_err", frame_err, 0);
    RST = 1'b1;
    step(2);
    @(negedge CLK);
    RST = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
